// File: rtl/vga_timing_scheduler.sv
// VGA raster timing (counters, syncs, active window) plus one-deep per-line prefetch
// scheduler with deadline-based underrun detection.
module vga_timing_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    output logic       H_pulse,
    output logic       V_pulse,
    output logic       ACTIVE,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       FRAME_START,
    output logic       LINE_REQ,
    output logic [9:0] LINE_NUM,
    input  logic       LINE_ACK,
    output logic       UNDERRUN,
    output logic [7:0] UNDERRUN_CNT
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_HT_M1  = 10'(HT - 1);
    localparam logic [9:0] C_VT_M1  = 10'(VT - 1);
    localparam logic [9:0] C_HA     = 10'(H_ACTIVE);
    localparam logic [9:0] C_VA     = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t     r_state, w_state_nx;
    logic       r_run;
    logic [9:0] r_x, r_y, r_line;
    logic [9:0] w_x_nx, w_y_nx, w_n_nx, w_line_nx;
    logic       w_wrap, w_underrun_nx;
    logic       r_h, r_v, r_active, r_fs, r_underrun;
    logic [7:0] r_ucnt;

    // r_run is low on the first enabled edge, so that edge holds (0,0).
    always_comb begin
        w_x_nx = 10'd0;
        w_y_nx = 10'd0;
        w_wrap = 1'b0;
        if (EN && r_run) begin
            if (r_x == C_HT_M1) begin
                w_wrap = 1'b1;
                w_y_nx = (r_y == C_VT_M1) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nx = r_x + 10'd1;
                w_y_nx = r_y;
            end
        end
    end

    assign w_n_nx = (w_y_nx == C_VT_M1) ? 10'd0 : w_y_nx + 10'd1;

    // An ack sampled on the deadline edge wins over the underrun.
    always_comb begin
        w_state_nx    = r_state;
        w_line_nx     = r_line;
        w_underrun_nx = 1'b0;
        if (!EN) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_x_nx == C_HA && w_n_nx < C_VA) begin
                        w_state_nx = S_REQ;
                        w_line_nx  = w_n_nx;
                    end
                end
                S_REQ: begin
                    if (LINE_ACK) begin
                        w_state_nx = S_IDLE;
                    end else if (w_wrap) begin
                        w_state_nx    = S_IDLE;
                        w_underrun_nx = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_line     <= 10'd0;
            r_h        <= 1'b1;
            r_v        <= 1'b1;
            r_active   <= 1'b0;
            r_fs       <= 1'b0;
            r_underrun <= 1'b0;
            r_ucnt     <= 8'd0;
        end else begin
            r_state    <= w_state_nx;
            r_run      <= EN;
            r_x        <= w_x_nx;
            r_y        <= w_y_nx;
            r_line     <= w_line_nx;
            r_h        <= !(EN && (w_x_nx >= C_HS_BEG) && (w_x_nx < C_HS_END));
            r_v        <= !(EN && (w_y_nx >= C_VS_BEG) && (w_y_nx < C_VS_END));
            r_active   <= EN && (w_x_nx < C_HA) && (w_y_nx < C_VA);
            r_fs       <= EN && (w_x_nx == 10'd0) && (w_y_nx == 10'd0);
            r_underrun <= w_underrun_nx;
            if (w_underrun_nx && (r_ucnt != 8'hFF)) begin
                r_ucnt <= r_ucnt + 8'd1;
            end
        end
    end

    assign H_pulse      = r_h;
    assign V_pulse      = r_v;
    assign ACTIVE       = r_active;
    assign PIX_X        = r_x;
    assign PIX_Y        = r_y;
    assign FRAME_START  = r_fs;
    assign LINE_REQ     = (r_state == S_REQ);
    assign LINE_NUM     = r_line;
    assign UNDERRUN     = r_underrun;
    assign UNDERRUN_CNT = r_ucnt;

endmodule

// File: tb/tb_vga_timing_scheduler.sv
// Bench for vga_timing_scheduler on a shrunken raster (32x19) so many frames fit in the run.
module tb_vga_timing_scheduler;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [43:0] RESET_VEC = {6'b110000, 38'd0};

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic EN = 1'b0;
  logic LINE_ACK = 1'b0;
  logic H_pulse, V_pulse, ACTIVE, FRAME_START, LINE_REQ, UNDERRUN;
  logic [9:0] PIX_X, PIX_Y, LINE_NUM;
  logic [7:0] UNDERRUN_CNT;

  int n_pass = 0;
  int n_chk = 0;
  logic chk_on = 1'b0;

  always #5 CLK = ~CLK;

  vga_timing_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
    .H_pulse(H_pulse), .V_pulse(V_pulse), .ACTIVE(ACTIVE),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .FRAME_START(FRAME_START),
    .LINE_REQ(LINE_REQ), .LINE_NUM(LINE_NUM), .LINE_ACK(LINE_ACK),
    .UNDERRUN(UNDERRUN), .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  logic [43:0] dut_v, dut_full;
  assign dut_v    = {H_pulse, V_pulse, ACTIVE, FRAME_START, LINE_REQ, UNDERRUN,
                     PIX_X, PIX_Y, UNDERRUN_CNT, (LINE_REQ ? LINE_NUM : 10'd0)};
  assign dut_full = {H_pulse, V_pulse, ACTIVE, FRAME_START, LINE_REQ, UNDERRUN,
                     PIX_X, PIX_Y, UNDERRUN_CNT, LINE_NUM};

  // Reference model: position in frame as one integer, pending line as int (-1 = none).
  typedef struct {
    logic en;
    int   pos;
    int   pend;
    int   line;
    logic under;
    int   cnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t s;
    s.en = 1'b0; s.pos = 0; s.pend = -1; s.line = 0; s.under = 1'b0; s.cnt = 0;
    return s;
  endfunction

  function automatic model_t model_step(input model_t s, input logic en, input logic ack);
    model_t n;
    int x, y;
    n = s;
    n.under = 1'b0;
    if (!en) begin
      n.en = 1'b0; n.pos = 0; n.pend = -1;
    end else begin
      n.pos = s.en ? (s.pos + 1) % FRAME : 0;
      n.en = 1'b1;
      x = n.pos % HT;
      y = n.pos / HT;
      if (n.pend >= 0) begin
        if (ack) n.pend = -1;
        else if (x == 0) begin
          n.under = 1'b1;
          if (n.cnt < 255) n.cnt = n.cnt + 1;
          n.pend = -1;
        end
      end
      if (n.pend < 0 && x == HA && ((y + 1) % VT) < VA) begin
        n.pend = (y + 1) % VT;
        n.line = n.pend;
      end
    end
    return n;
  endfunction

  function automatic logic [43:0] exp_vec(input model_t s);
    int x, y;
    logic h, v, a, f, r;
    logic [9:0] ln;
    x = s.pos % HT;
    y = s.pos / HT;
    h = !(s.en && x >= HA + HFP && x < HA + HFP + HS);
    v = !(s.en && y >= VA + VFP && y < VA + VFP + VS);
    a = s.en && x < HA && y < VA;
    f = s.en && s.pos == 0;
    r = s.pend >= 0;
    ln = r ? 10'(s.line) : 10'd0;
    return {h, v, a, f, r, s.under, 10'(x), 10'(y), 8'(s.cnt), ln};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= model_reset();
    else m <= model_step(m, EN, LINE_ACK);
  end

  // Scoreboard: every cycle, DUT outputs vs model.
  always @(negedge CLK) begin
    if (chk_on) begin
      n_chk++;
      if (dut_v === exp_vec(m)) n_pass++;
      else $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, dut_v, exp_vec(m));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting, got no event expected one (t=%0t)", name, $time);
  endtask

  typedef struct {
    int k;
    logic [9:0] x;
    logic [9:0] y;
    logic h, v, a, f;
  } vec_t;

  vec_t tbl[13];

  task automatic delayed_ack(input int d, input string name);
    int len, guard;
    logic seen_under;
    guard = 0;
    while (LINE_REQ && guard < 4 * HT) begin @(negedge CLK); guard++; end
    LINE_ACK = 1'b0;
    guard = 0;
    while (!LINE_REQ && guard < 4 * HT) begin @(negedge CLK); guard++; end
    if (!LINE_REQ) begin
      fail_timeout(name);
      LINE_ACK = 1'b1;
      return;
    end
    len = 1;
    seen_under = 1'b0;
    if (len == d) LINE_ACK = 1'b1;
    guard = 0;
    while (guard < 2 * HT) begin
      @(negedge CLK);
      guard++;
      if (UNDERRUN) seen_under = 1'b1;
      if (!LINE_REQ) break;
      len++;
      if (len == d) LINE_ACK = 1'b1;
    end
    check({name, "_len"}, 64'(len), 64'(d));
    check({name, "_underrun"}, 64'(seen_under), 64'd0);
    LINE_ACK = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_q[$];
    int cyc, nreq, bad, guard, npulse;
    logic prev, got_dl, done;

    tbl[0]  = '{1,   10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,   10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{16,  10'd15, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{17,  10'd16, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{21,  10'd20, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{26,  10'd25, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{27,  10'd26, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{33,  10'd0,  10'd1,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{385, 10'd0,  10'd12, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{449, 10'd0,  10'd14, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{512, 10'd31, 10'd15, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{513, 10'd0,  10'd16, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{609, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1};

    // Clock/reset
    #1 RST_N = 1'b0;
    #11;
    check("reset", 64'(dut_full), 64'(RESET_VEC));
    @(negedge CLK);
    RST_N = 1'b1; EN = 1'b1; LINE_ACK = 1'b1; chk_on = 1'b1;

    // Raster timing table, ack tied high
    cyc = 0;
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].k) begin @(negedge CLK); cyc++; end
      check($sformatf("tbl%0d", i),
            64'({PIX_X, PIX_Y, H_pulse, V_pulse, ACTIVE, FRAME_START}),
            64'({tbl[i].x, tbl[i].y, tbl[i].h, tbl[i].v, tbl[i].a, tbl[i].f}));
    end

    // One full frame of requests
    for (int y = 0; y < VT; y++)
      if (((y + 1) % VT) < VA) exp_q.push_back(10'((y + 1) % VT));
    nreq = 0; bad = 0; prev = LINE_REQ;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge CLK);
      if (LINE_REQ && !prev) begin
        nreq++;
        if (int'(PIX_Y) >= VA && int'(PIX_Y) <= VT - 2) bad++;
        check("sweep_x", 64'(PIX_X), 64'(HA));
        if (exp_q.size() > 0) check("sweep_line", 64'(LINE_NUM), 64'(exp_q.pop_front()));
      end
      prev = LINE_REQ;
    end
    check("sweep_count", 64'(nreq), 64'd12);
    check("sweep_vblank", 64'(bad), 64'd0);

    // Delayed acks: mid-window and exactly on the deadline edge
    delayed_ack(10, "ack_delay10");
    delayed_ack(HT - HA, "ack_on_deadline");
    check("ucnt_after_acks", 64'(UNDERRUN_CNT), 64'd0);

    // Withhold the ack for line 5 only
    guard = 0;
    while (PIX_Y != 10'd0 && guard < 2 * FRAME) begin @(negedge CLK); guard++; end
    got_dl = 1'b0; done = 1'b0; npulse = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge CLK);
      if (UNDERRUN) npulse++;
      if (PIX_X == 10'd0 && PIX_Y == 10'd5 && !got_dl) begin
        got_dl = 1'b1;
        check("l5_req_drop", 64'(LINE_REQ), 64'd0);
        check("l5_underrun", 64'(UNDERRUN), 64'd1);
        check("l5_cnt", 64'(UNDERRUN_CNT), 64'd1);
      end
      if (int'(PIX_X) == HA && PIX_Y == 10'd5) begin
        check("l6_req", 64'(LINE_REQ), 64'd1);
        check("l6_num", 64'(LINE_NUM), 64'd6);
        done = 1'b1;
      end
      LINE_ACK = !(LINE_REQ && LINE_NUM == 10'd5);
      if (done) break;
    end
    LINE_ACK = 1'b1;
    if (!done) fail_timeout("line5_withhold");
    check("l5_pulses", 64'(npulse), 64'd1);

    // EN dropped inside both sync regions
    guard = 0;
    while (!(int'(PIX_Y) == VA + VFP && int'(PIX_X) == HA + HFP + 2) && guard < 2 * FRAME) begin
      @(negedge CLK); guard++;
    end
    check("endrop_pre_sync", 64'({H_pulse, V_pulse}), 64'd0);
    EN = 1'b0;
    @(negedge CLK);
    check("endrop", 64'({PIX_X, PIX_Y, H_pulse, V_pulse, ACTIVE, LINE_REQ, FRAME_START, UNDERRUN_CNT}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}));
    repeat (3) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    check("en_rise0", 64'({PIX_X, PIX_Y, FRAME_START}), 64'({10'd0, 10'd0, 1'b1}));
    @(negedge CLK);
    check("en_rise1", 64'({PIX_X, PIX_Y, FRAME_START}), 64'({10'd1, 10'd0, 1'b0}));

    // Saturation: no acks for 26 frames (312 requests)
    LINE_ACK = 1'b0;
    repeat (26 * FRAME) @(negedge CLK);
    check("sat_cnt", 64'(UNDERRUN_CNT), 64'd255);
    LINE_ACK = 1'b1;

    // Async reset in the middle of an outstanding request
    guard = 0;
    while (LINE_REQ && guard < 4 * HT) begin @(negedge CLK); guard++; end
    LINE_ACK = 1'b0;
    guard = 0;
    while (!(LINE_REQ && int'(PIX_X) == HA + 4) && guard < 2 * FRAME) begin @(negedge CLK); guard++; end
    if (!(LINE_REQ && int'(PIX_X) == HA + 4)) fail_timeout("reset_setup");
    #2 RST_N = 1'b0;
    #1 check("async_reset", 64'(dut_full), 64'(RESET_VEC));
    @(negedge CLK);
    RST_N = 1'b1; LINE_ACK = 1'b1;
    @(negedge CLK);
    check("restart", 64'({PIX_X, PIX_Y, FRAME_START}), 64'({10'd0, 10'd0, 1'b1}));

    // Randomized run against the model
    for (int c = 0; c < 8000; c++) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 199) != 0);
      LINE_ACK = ($urandom_range(0, 3) == 0);
    end

    @(negedge CLK);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
